// File: rtl/sha256_pkg.sv
// SHA-256 padder shared definitions: block geometry, pad marker, FSM states, block count helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package sha256_pkg;

    localparam int          SHA_BLOCK_WORDS = 16;
    localparam logic [31:0] SHA_PAD_WORD    = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    // Blocks needed for len message words plus the marker word and the two
    // length words: ceil((len + 3) / 16) == (len + 18) >> 4.
    function automatic logic [31:0] num_blocks(input logic [31:0] len);
        return (len + 32'd18) >> 4;
    endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Padded-block stream between the padder and the compression core.
// Latency: n/a (wires only).
// Backpressure: producer holds block_valid and the payload until block_valid & block_ready.
// Ports: block_valid/block_data/block_last/block_index from master, block_ready from slave.
interface sha256_msg_padder_if #(
    parameter int BLK_W = 13
) ();

    logic             block_valid;
    logic             block_ready;
    logic [511:0]     block_data;
    logic             block_last;
    logic [BLK_W-1:0] block_index;

    modport master (
        output block_valid,
        output block_data,
        output block_last,
        output block_index,
        input  block_ready
    );

    modport slave (
        input  block_valid,
        input  block_data,
        input  block_last,
        input  block_index,
        output block_ready
    );

endinterface

// File: rtl/sha256_pad_word.sv
// Value of one padded-message word: memory data, pad marker, zero fill or bit-length.
// Latency: combinational.
// Backpressure: none.
// Ports: g_i global word index, len_i message length, idx_i word-in-block, is_last_i,
//        mem_rdata_i read data; word_o resulting word, use_mem_o word comes from memory.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int GW    = 17
) (
    input  logic [GW-1:0]    g_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [3:0]       idx_i,
    input  logic             is_last_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [31:0]      word_o,
    output logic             use_mem_o
);

    logic [63:0]         len_bits;
    logic [GW+LEN_W-1:0] g_wide;
    logic [GW+LEN_W-1:0] len_wide;

    always_comb begin
        len_bits  = 64'(len_i) << 5;
        // Compare in a width that holds both operands whatever the parameters.
        g_wide    = {LEN_W'(0), g_i};
        len_wide  = {GW'(0), len_i};
        word_o    = '0;
        use_mem_o = 1'b0;
        if (is_last_i && idx_i == 4'd14) begin
            word_o = len_bits[63:32];
        end else if (is_last_i && idx_i == 4'd15) begin
            word_o = len_bits[31:0];
        end else if (g_wide < len_wide) begin
            word_o    = mem_rdata_i;
            use_mem_o = 1'b1;
        end else if (g_wide == len_wide) begin
            word_o = SHA_PAD_WORD;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a message from word memory and emits SHA-256 padded 512-bit blocks.
// Latency: 17 FETCH cycles per block (read issued cycle w, word w written cycle w+1), then PRESENT.
// Backpressure: block held in PRESENT with payload stable until block_ready; no reads while held.
// Ports: clk/rst; start, input_addr, msg_words request; mem_addr/mem_re/mem_rdata memory
//        (1-cycle read latency); blk block stream (master); busy, done status.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16,
    parameter int BLK_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] input_addr,
    input  logic [LEN_W-1:0]  msg_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    sha256_msg_padder_if.master blk,
    output logic              busy,
    output logic              done
);

    localparam int GW = BLK_W + 4;

    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [BLK_W-1:0]      nblk_q;
    logic [BLK_W-1:0]      b_q;
    logic [4:0]            w_q;
    logic [0:15][31:0]     buf_q;     // word 0 lands in the top bits
    logic                  valid_q;
    logic                  last_q;
    logic [BLK_W-1:0]      index_q;
    logic                  done_q;

    logic [GW-1:0]         blk_base;
    logic [GW-1:0]         g_rd;
    logic [GW-1:0]         g_wr;
    logic [3:0]            wr_idx;
    logic                  is_last;
    logic                  rd_in_msg;
    logic [31:0]           gen_word;
    logic                  use_mem;
    logic [31:0]           wr_word_d;

    // Read side addresses word w; write side fills word w-1 (wraps to 15 at w=16).
    assign blk_base  = {b_q, 4'b0000};
    assign g_rd      = blk_base + GW'(w_q[3:0]);
    assign wr_idx    = w_q[3:0] - 4'd1;
    assign g_wr      = blk_base + GW'(wr_idx);
    assign is_last   = (b_q == nblk_q - BLK_W'(1));
    assign rd_in_msg = {LEN_W'(0), g_rd} < {GW'(0), len_q};

    assign mem_re    = (state_q == FETCH) && !w_q[4] && rd_in_msg;
    assign mem_addr  = mem_re ? (addr_q + ADDR_W'(g_rd)) : '0;

    sha256_pad_word #(
        .LEN_W (LEN_W),
        .GW    (GW)
    ) u_pad_word (
        .g_i         (g_wr),
        .len_i       (len_q),
        .idx_i       (wr_idx),
        .is_last_i   (is_last),
        .mem_rdata_i (mem_rdata),
        .word_o      (gen_word),
        .use_mem_o   (use_mem)
    );

    assign wr_word_d = use_mem ? mem_rdata : gen_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            nblk_q  <= '0;
            b_q     <= '0;
            w_q     <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= input_addr;
                        len_q   <= msg_words;
                        nblk_q  <= BLK_W'(num_blocks(32'(msg_words)));
                        b_q     <= '0;
                        w_q     <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_q != 5'd0) begin
                        buf_q[wr_idx] <= wr_word_d;
                    end
                    if (w_q == 5'd16) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                        last_q  <= is_last;
                        index_q <= b_q;
                    end else begin
                        w_q <= w_q + 5'd1;
                    end
                end
                PRESENT: begin
                    if (blk.block_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            b_q     <= b_q + BLK_W'(1);
                            w_q     <= '0;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk.block_valid = valid_q;
    assign blk.block_data  = buf_q;
    assign blk.block_last  = last_q;
    assign blk.block_index = index_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed and random messages against a padded-message queue model.
// Latency: checks valid 18 edges after the start/transfer edge, counting that edge as the first.
// Backpressure: stalls ready in PRESENT and checks the held block and absence of reads.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] input_addr;
    logic [15:0] msg_words;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    sha256_msg_padder_if #(.BLK_W(13)) blk ();

    sha256_msg_padder #(
        .ADDR_W (16),
        .LEN_W  (16),
        .BLK_W  (13)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .input_addr (input_addr),
        .msg_words  (msg_words),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .blk        (blk),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Word memory with one-cycle read latency; garbage on idle cycles.
    logic [31:0] mem [0:65535];
    logic [15:0] rd_q [$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            rd_q.push_back(mem_addr);
        end else begin
            mem_rdata <= $urandom;
        end
        if (done) done_cnt++;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole padded message as a word list: data, marker, zeros to 14 mod 16, 64-bit bit length.
    task automatic build_model(input logic [15:0] a, input int len);
        logic [63:0] nbits;
        logic [15:0] ad;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            ad = a + 16'(k);
            exp_q.push_back(mem[ad]);
        end
        exp_q.push_back(32'h8000_0000);
        while (exp_q.size() % 16 != 14) exp_q.push_back(32'h0);
        nbits = 64'(len) * 64'd32;
        exp_q.push_back(nbits[63:32]);
        exp_q.push_back(nbits[31:0]);
    endtask

    task automatic fill_rand(input logic [15:0] a, input int len);
        logic [15:0] ad;
        for (int k = 0; k < len; k++) begin
            ad = a + 16'(k);
            mem[ad] = $urandom;
        end
    endtask

    task automatic run_msg(input logic [15:0] a, input int len, input bit stall, input bit poke,
                           output logic [511:0] last_blk);
        int           nblk, edges, rd0, dn0, mre0, nbad_addr;
        logic [511:0] expb;
        logic [15:0]  ad;
        build_model(a, len);
        nblk = exp_q.size() / 16;
        rd0  = rd_q.size();
        dn0  = done_cnt;
        expb = '0;
        last_blk = '0;
        @(negedge clk);
        input_addr = a;
        msg_words  = 16'(len);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        input_addr = 16'($urandom);
        msg_words  = 16'($urandom);
        edges      = 1;
        for (int b = 0; b < nblk; b++) begin
            while (!blk.block_valid && edges < 40) begin
                start = (poke && b == 0 && edges == 5);
                @(negedge clk);
                edges++;
            end
            start = 1'b0;
            chk($sformatf("latency L%0d b%0d", len, b), 512'(edges), 512'(18));
            for (int i = 0; i < 16; i++) expb[511 - 32*i -: 32] = exp_q[16*b + i];
            chk($sformatf("data L%0d b%0d", len, b), blk.block_data, expb);
            chk($sformatf("index L%0d b%0d", len, b), 512'(blk.block_index), 512'(b));
            chk($sformatf("last L%0d b%0d", len, b), 512'(blk.block_last), 512'(b == nblk - 1));
            chk($sformatf("busy L%0d b%0d", len, b), 512'(busy), 512'(1));
            if (stall && b == 0) begin
                mre0 = rd_q.size();
                repeat (10) @(negedge clk);
                chk("stall data", blk.block_data, expb);
                chk("stall index", 512'(blk.block_index), 512'(0));
                chk("stall valid", 512'(blk.block_valid), 512'(1));
                chk("stall no reads", 512'(rd_q.size()), 512'(mre0));
            end
            last_blk = blk.block_data;
            blk.block_ready = 1'b1;
            @(negedge clk);
            blk.block_ready = 1'b0;
            edges = 1;
        end
        chk($sformatf("done high L%0d", len), 512'(done), 512'(1));
        @(negedge clk);
        chk($sformatf("done pulse L%0d", len), 512'(done), 512'(0));
        chk($sformatf("idle L%0d", len), 512'(busy), 512'(0));
        chk($sformatf("done count L%0d", len), 512'(done_cnt - dn0), 512'(1));
        chk($sformatf("read count L%0d", len), 512'(rd_q.size() - rd0), 512'(len));
        nbad_addr = 0;
        for (int k = 0; k < len && rd0 + k < rd_q.size(); k++) begin
            ad = a + 16'(k);
            if (rd_q[rd0 + k] !== ad) nbad_addr++;
        end
        chk($sformatf("read addrs L%0d", len), 512'(nbad_addr), 512'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, 512'({mem_addr, mem_re, blk.block_valid, blk.block_last,
                                 blk.block_index, busy, done}), 512'(0));
        chk({tag, " data"}, blk.block_data, 512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] lb;
        int           edges, dn0, len, stall;
        logic [15:0]  a;

        rst = 1'b1;
        start = 1'b0;
        input_addr = '0;
        msg_words = '0;
        blk.block_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post reset");

        // Pattern message: word k = 0x1000_0000 + k.
        for (int k = 0; k < 40; k++) mem[16'h0100 + 16'(k)] = 32'h1000_0000 + 32'(k);
        run_msg(16'h0100, 40, 1'b0, 1'b0, lb);
        chk("L40 b2 w0", 512'(lb[511:480]), 512'(32'h1000_0020));
        chk("L40 b2 w7", 512'(lb[287:256]), 512'(32'h1000_0027));
        chk("L40 b2 w8", 512'(lb[255:224]), 512'(32'h8000_0000));
        chk("L40 b2 w15", 512'(lb[31:0]), 512'(32'h0000_0500));

        run_msg(16'h2000, 0, 1'b0, 1'b0, lb);
        chk("L0 block", lb, {32'h8000_0000, 480'h0});

        fill_rand(16'h3000, 13);
        run_msg(16'h3000, 13, 1'b0, 1'b0, lb);
        chk("L13 w13", 512'(lb[95:64]), 512'(32'h8000_0000));
        chk("L13 w15", 512'(lb[31:0]), 512'(32'h0000_01A0));

        fill_rand(16'h4000, 14);
        run_msg(16'h4000, 14, 1'b0, 1'b0, lb);
        chk("L14 b1", lb, 512'(32'h0000_01C0));

        // Backpressure on block 0 plus a start pulse while busy.
        fill_rand(16'h5000, 20);
        run_msg(16'h5000, 20, 1'b1, 1'b1, lb);

        // Reset during FETCH of block 1 abandons the message.
        fill_rand(16'h6000, 30);
        @(negedge clk);
        input_addr = 16'h6000;
        msg_words = 16'd30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (!blk.block_valid && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk("rst run b0 valid", 512'(blk.block_valid), 512'(1));
        blk.block_ready = 1'b1;
        @(negedge clk);
        blk.block_ready = 1'b0;
        repeat (5) @(negedge clk);
        dn0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid reset");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("no done after reset", 512'(done_cnt - dn0), 512'(0));
        chk("idle after reset", 512'(busy), 512'(0));
        fill_rand(16'h7000, 17);
        run_msg(16'h7000, 17, 1'b0, 1'b0, lb);

        // Address wrap.
        fill_rand(16'hFFFE, 4);
        run_msg(16'hFFFE, 4, 1'b0, 1'b0, lb);

        for (int t = 0; t < 4; t++) begin
            a     = 16'($urandom);
            len   = $urandom_range(0, 50);
            stall = $urandom_range(0, 1);
            fill_rand(a, len);
            run_msg(a, len, stall[0], 1'b0, lb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
